vec_loader_x: RTL

Serial-to-parallel operand loader for the input-side LSTM gate dot-product path. It accepts one (x, w) element pair per cycle over a valid/ready stream and assembles VECTWIDTH pairs into the packed data_x / W_x buses consumed by the vecmat_x_* dot-product blocks. It handles short frames by zero-filling unused lanes. It presents each completed vector with a valid/ready handshake.

---
 rtl/vec_loader_x.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vec_loader_x.sv
// vec_loader_x: serial-to-parallel (x, w) operand loader feeding the LSTM input-gate dot product.
// Optional build macro VEC_LOADER_DBUF_EN adds a present buffer so the next frame fills during hand-off.
module vec_loader_x #(
    parameter int VECTWIDTH  = 100,
    parameter int ELEM_WIDTH = 16,
    parameter int VARRAYSIZE = VECTWIDTH * ELEM_WIDTH,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_WIDTH-1:0] in_x,
    input  logic [ELEM_WIDTH-1:0] in_w,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VARRAYSIZE-1:0] data_x,
    output logic [VARRAYSIZE-1:0] W_x,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  err_len
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTWIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]  frame_cnt;
    logic [CNT_WIDTH-1:0]  cnt_wr;
    logic [VARRAYSIZE-1:0] fill_x;
    logic [VARRAYSIZE-1:0] fill_w;
    logic [VARRAYSIZE-1:0] fill_x_wr;
    logic [VARRAYSIZE-1:0] fill_w_wr;
    logic                  accept;
    logic                  at_end;
    logic                  complete;
    logic                  fill_clear;

    assign accept   = in_valid && in_ready;
    assign at_end   = (idx == LAST_IDX);
    assign complete = accept && (at_end || in_last);
    assign cnt_wr   = idx + CNT_WIDTH'(1);

    // Fill buffer with the accepted element merged into lane idx.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        fill_x_wr = fill_x;
        fill_w_wr = fill_w;
        for (int i = 0; i < VECTWIDTH; i++) begin
            if (accept && (idx == CNT_WIDTH'(i))) begin
                fill_x_wr[i*ELEM_WIDTH +: ELEM_WIDTH] = in_x;
                fill_w_wr[i*ELEM_WIDTH +: ELEM_WIDTH] = in_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset) begin
            idx       <= '0;
            frame_cnt <= '0;
            err_len   <= 1'b0;
        end else begin
            err_len <= accept && at_end && !in_last;
            if (complete) begin
                idx       <= '0;
                frame_cnt <= cnt_wr;
            end else if (accept) begin
                idx <= cnt_wr;
            end
        end
    end

    // NOTE: the fill buffer data itself is reset, because zero-filled short frames rely on it starting at zero.
    always_ff @(posedge clk) begin
        if (!reset || fill_clear) begin
            fill_x <= '0;
            fill_w <= '0;
        end else if (accept) begin
            fill_x <= fill_x_wr;
            fill_w <= fill_w_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

`ifdef VEC_LOADER_DBUF_EN
    logic                  pres_valid;
    logic                  pres_free;
    logic                  load_pres;
    logic [CNT_WIDTH-1:0]  pres_count;
    logic [VARRAYSIZE-1:0] pres_x;
    logic [VARRAYSIZE-1:0] pres_w;

    assign pres_free = !pres_valid || out_ready;

    // S_FULL here means a completed frame sits in the fill buffer waiting for the present buffer.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (complete && !pres_free) state_next = S_FULL;
            S_FULL:  if (pres_free) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    always_comb begin
        in_ready   = reset && (state == S_FILL);
        load_pres  = pres_free && (complete || (state == S_FULL));
        fill_clear = load_pres;
        out_valid  = pres_valid;
        data_x     = pres_valid ? pres_x : fill_x;
        W_x        = pres_valid ? pres_w : fill_w;
        out_count  = pres_count;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pres_valid <= 1'b0;
            pres_count <= '0;
        end else if (load_pres) begin
            pres_valid <= 1'b1;
            pres_count <= complete ? cnt_wr : frame_cnt;
        end else if (out_ready) begin
            pres_valid <= 1'b0;
        end
    end

    // Present data needs no reset: while empty, the output mux shows the (reset) fill buffer.
    always_ff @(posedge clk) begin
        if (load_pres) begin
            pres_x <= fill_x_wr;
            pres_w <= fill_w_wr;
        end
    end
`else
    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (complete) state_next = S_FULL;
            S_FULL:  if (out_ready) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    // The fill buffer is presented directly; it stays frozen while S_FULL blocks new accepts.
    always_comb begin
        in_ready   = reset && (state == S_FILL);
        out_valid  = (state == S_FULL);
        fill_clear = out_valid && out_ready;
        data_x     = fill_x;
        W_x        = fill_w;
        out_count  = frame_cnt;
    end
`endif

endmodule
